// File: rtl/wbs_pwm_capture_pkg.sv
// Shared definitions for the PWM capture slave: word select, word0 bit positions, channel limit.
package wbs_pwm_capture_pkg;

    localparam int   MAX_CHANNELS = 8;
    localparam int   VALID_BIT    = 31;
    localparam int   LEVEL_BIT    = 30;

    localparam logic WORD_STATUS  = 1'b0;
    localparam logic WORD_PERIOD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wbs_pwm_capture_channel.sv
// One capture channel: 2-FF sync, optional majority filter (WBS_PWM_CAPTURE_FILTER_EN), counters, latch.
// Edge-to-latch latency 3 clocks (5 with filter); no backpressure, measurements overwrite.
module wbs_pwm_capture_channel
    import wbs_pwm_capture_pkg::*;
#(
    parameter int COUNTER_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pwm,
    input  logic                 i_rd0,
    output logic                 o_valid,
    output logic                 o_level,
    output logic [COUNTER_W-1:0] o_high,
    output logic [COUNTER_W-1:0] o_shadow
);

    localparam logic [COUNTER_W-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_W-1:0] CNT_ONE = COUNTER_W'(1);
    localparam logic [COUNTER_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic                 r_armed;
    logic                 r_valid;
    logic [COUNTER_W-1:0] r_cnt_p;
    logic [COUNTER_W-1:0] r_cnt_h;
    logic [COUNTER_W-1:0] r_period;
    logic [COUNTER_W-1:0] r_high;
    logic [COUNTER_W-1:0] r_shadow;

    logic                 w_in;
    logic                 w_rise;
    logic                 w_timeout;
    logic                 w_latch;

`ifdef WBS_PWM_CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            r_filt <= maj3(r_sync2, r_hist[0], r_hist[1]);
        end
    end

    assign w_in = r_filt;
`else
    assign w_in = r_sync2;
`endif

    assign w_rise    = w_in & ~r_prev;
    // Fires on the single tick the period counter steps onto MAX, so it never repeats while saturated.
    assign w_timeout = ~w_rise & (r_cnt_p == CNT_PRE);
    assign w_latch   = (w_rise & r_armed) | w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_armed  <= 1'b0;
            r_valid  <= 1'b0;
            r_cnt_p  <= '0;
            r_cnt_h  <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_shadow <= '0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
            r_prev  <= w_in;

            if (w_rise) begin
                r_cnt_p <= CNT_ONE;
                r_cnt_h <= CNT_ONE;
            end else begin
                if (r_cnt_p != CNT_MAX) r_cnt_p <= r_cnt_p + CNT_ONE;
                if (w_in && (r_cnt_h != CNT_MAX)) r_cnt_h <= r_cnt_h + CNT_ONE;
            end

            if (w_rise)         r_armed <= 1'b1;
            else if (w_timeout) r_armed <= 1'b0;

            if (w_rise && r_armed) begin
                r_period <= r_cnt_p;
                r_high   <= r_cnt_h;
            end else if (w_timeout) begin
                r_period <= '0;
                r_high   <= w_in ? CNT_MAX : '0;
            end

            // A fresh measurement beats a simultaneous status read.
            if (w_latch)    r_valid <= 1'b1;
            else if (i_rd0) r_valid <= 1'b0;

            if (i_rd0) r_shadow <= r_period;
        end
    end

    assign o_valid  = r_valid;
    assign o_level  = w_in;
    assign o_high   = r_high;
    assign o_shadow = r_shadow;

endmodule

// File: rtl/wbs_pwm_capture.sv
// Wishbone pipelined PWM capture slave; optional input filter via WBS_PWM_CAPTURE_FILTER_EN.
// Ack and read data one cycle after the request; never stalls, writes acked and dropped.
module wbs_pwm_capture
    import wbs_pwm_capture_pkg::*;
#(
    parameter int CHANNEL_NUM = 1,
    parameter int COUNTER_W   = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_stall_o,
    output logic                   wb_ack_o,
    input  logic [CHANNEL_NUM-1:0] pwm_channel_i
);

    logic                    w_req;
    logic                    w_rd;
    logic                    w_rd0;
    logic [2:0]              w_chan;
    logic                    w_unused;
    logic [MAX_CHANNELS-1:0] w_valid;
    logic [MAX_CHANNELS-1:0] w_level;
    logic [COUNTER_W-1:0]    w_high   [MAX_CHANNELS];
    logic [COUNTER_W-1:0]    w_shadow [MAX_CHANNELS];
    logic [31:0]             w_word0;
    logic [31:0]             w_word1;
    logic [31:0]             w_rdata;

    logic                    r_ack;
    logic [31:0]             r_dat;

    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_rd     = w_req & ~wb_we_i;
    assign w_rd0    = w_rd & (wb_adr_i[0] == WORD_STATUS);
    assign w_chan   = wb_adr_i[3:1];
    assign w_unused = ^wb_dat_i;

    // Unpopulated slots are tied to zero so out-of-range channels read back 0.
    for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_ch
        if (c < CHANNEL_NUM) begin : g_on
            wbs_pwm_capture_channel #(
                .COUNTER_W (COUNTER_W)
            ) u_chan (
                .i_clk    (wb_clk_i),
                .i_rst_n  (wb_rst_ni),
                .i_pwm    (pwm_channel_i[c]),
                .i_rd0    (w_rd0 && (w_chan == 3'(c))),
                .o_valid  (w_valid[c]),
                .o_level  (w_level[c]),
                .o_high   (w_high[c]),
                .o_shadow (w_shadow[c])
            );
        end else begin : g_off
            assign w_valid[c]  = 1'b0;
            assign w_level[c]  = 1'b0;
            assign w_high[c]   = '0;
            assign w_shadow[c] = '0;
        end
    end

    always_comb begin
        w_word0                  = '0;
        w_word0[COUNTER_W-1:0]   = w_high[w_chan];
        w_word0[VALID_BIT]       = w_valid[w_chan];
        w_word0[LEVEL_BIT]       = w_level[w_chan];
        w_word1                  = '0;
        w_word1[COUNTER_W-1:0]   = w_shadow[w_chan];
        w_rdata                  = (wb_adr_i[0] == WORD_PERIOD) ? w_word1 : w_word0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_rd) r_dat <= w_rdata;
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wbs_pwm_capture.sv
// Bench for wbs_pwm_capture (2 channels, 8-bit counters): bus reads queue expected words, ack monitor compares.
module tb_wbs_pwm_capture;

    localparam int CH_N = 2;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [3:0]      adr;
    logic [31:0]     dat_i;
    logic [31:0]     dat_o;
    logic            stall;
    logic            ack;
    logic [CH_N-1:0] pwm;

    always #5 clk = ~clk;

    wbs_pwm_capture #(
        .CHANNEL_NUM (CH_N),
        .COUNTER_W   (CW)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat_i),
        .wb_dat_o      (dat_o),
        .wb_stall_o    (stall),
        .wb_ack_o      (ack),
        .pwm_channel_i (pwm)
    );

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          cyc_cnt = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          iss_q [$];
    bit          wr_q  [$];

    logic [31:0] m_exp;
    string       m_tag;
    int          m_iss;
    bit          m_wr;

    logic [31:0] t6_w0;
    logic [31:0] t6_w1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            check("ack_outstanding", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                m_exp = exp_q.pop_front();
                m_tag = tag_q.pop_front();
                m_iss = iss_q.pop_front();
                m_wr  = wr_q.pop_front();
                check({m_tag, "_lat"}, 32'(cyc_cnt - m_iss), 32'd1);
                if (!m_wr) check(m_tag, dat_o, m_exp);
            end
        end
    end

    function automatic logic [3:0] adr_of(input int ch, input bit word);
        return {3'(ch), word};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus(input bit wr, input logic [3:0] a, input logic [31:0] e, input string tag);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr;
        adr   = a;
        dat_i = $urandom;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        iss_q.push_back(cyc_cnt);
        wr_q.push_back(wr);
        step(1);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic settle;
        step(3);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = '0;
        dat_i = '0;
        pwm   = '0;
        step(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step(2);
        bus(0, adr_of(0, 0), 32'h0000_0000, "init_w0");
        bus(0, adr_of(0, 1), 32'h0000_0000, "init_w1");
        settle();

        // 3 high / 5 low on channel 0
        for (int i = 0; i < 5; i++) begin
            pwm[0] = 1'b1; step(3);
            pwm[0] = 1'b0; step(5);
        end
        step(10);
        bus(0, adr_of(0, 0), 32'h8000_0003, "t1_w0");
        bus(0, adr_of(0, 1), 32'd8,         "t1_w1");
        bus(0, adr_of(0, 0), 32'h0000_0003, "t1_w0_again");
        settle();

        // timeout low, then timeout high
        step(266);
        bus(0, adr_of(0, 0), 32'h8000_0000, "t2_low_w0");
        bus(0, adr_of(0, 1), 32'h0000_0000, "t2_low_w1");
        settle();
        pwm[0] = 1'b1;
        step(266);
        bus(0, adr_of(0, 0), 32'hC000_00FF, "t2_high_w0");
        bus(0, adr_of(0, 1), 32'h0000_0000, "t2_high_w1");
        settle();
        step(20);
        bus(0, adr_of(0, 0), 32'h4000_00FF, "t2_no_repeat");
        settle();

        // reset mid-period with an ack in flight
        pwm[0] = 1'b0; step(5);
        pwm[0] = 1'b1; step(2);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = adr_of(0, 0);
        step(1);
        check("ack_pre_rst", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dat", dat_o, 32'd0);
        pwm[0] = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        bus(0, adr_of(0, 0), 32'h0000_0000, "t3_w0_after_rst");
        bus(0, adr_of(0, 1), 32'h0000_0000, "t3_w1_after_rst");
        settle();
        pwm[0] = 1'b1; step(3);
        pwm[0] = 1'b0; step(10);
        bus(0, adr_of(0, 0), 32'h0000_0000, "t3_arm_only");
        settle();
        step(6);
        pwm[0] = 1'b1; step(3);
        pwm[0] = 1'b0; step(10);
        bus(0, adr_of(0, 0), 32'h8000_0003, "t3_w0");
        bus(0, adr_of(0, 1), 32'd23,        "t3_w1");
        settle();

        // 1-clock low glitch inside an 8-clock high phase, rises 16 apart
        pwm[0] = 1'b1; step(3);
        pwm[0] = 1'b0; step(1);
        pwm[0] = 1'b1; step(4);
        pwm[0] = 1'b0; step(8);
        pwm[0] = 1'b1; step(3);
        pwm[0] = 1'b0; step(8);
`ifdef WBS_PWM_CAPTURE_FILTER_EN
        t6_w0 = 32'h8000_0008;
        t6_w1 = 32'd16;
`else
        t6_w0 = 32'h8000_0004;
        t6_w1 = 32'd12;
`endif
        bus(0, adr_of(0, 0), t6_w0, "t6_glitch_w0");
        bus(0, adr_of(0, 1), t6_w1, "t6_glitch_w1");
        settle();

        // channel 1: coherence, writes, back-to-back, out-of-range channel
        pwm[1] = 1'b1; step(2);
        pwm[1] = 1'b0; step(4);
        pwm[1] = 1'b1; step(2);
        pwm[1] = 1'b0; step(4);
        bus(1, adr_of(1, 0), 32'h0,         "t5_write");
        bus(0, adr_of(1, 0), 32'h8000_0002, "t4_w0");
        step(1);
        pwm[1] = 1'b1; step(2);
        pwm[1] = 1'b0; step(4);
        bus(0, adr_of(1, 1), 32'd6,         "t4_w1_shadow");
        bus(0, adr_of(1, 0), 32'h8000_0002, "t4_w0_new");
        bus(0, adr_of(1, 1), 32'd9,         "t4_w1_new");
        bus(1, adr_of(1, 1), 32'h0,         "t5_write2");
        bus(0, adr_of(1, 0), 32'h0000_0002, "t5_w0_after_wr");
        bus(0, adr_of(1, 1), 32'd9,         "t5_w1_after_wr");
        bus(0, adr_of(7, 0), 32'h0000_0000, "t4_ch7_w0");
        bus(0, adr_of(7, 1), 32'h0000_0000, "t4_ch7_w1");
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
